// File: rtl/sub_pkg.sv
// Shared constants for the registered ripple-borrow subtractor.
package sub_pkg;

    // Default operand / difference width.
    localparam int DATA_W = 8;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;
    assign d       = a_xor_b ^ bin;
    // Borrow when b exceeds a outright, or when a == b and a borrow arrives.
    assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule : full_subtractor

// File: rtl/subtractor_8_bit.sv
// Registered ripple-borrow subtractor: {Borrow_out, DIFF} <= A - B - Borrow_in,
// one clock of latency, cascadable through Borrow_in / Borrow_out.
module subtractor_8_bit
    import sub_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Borrow_in,
    output logic [WIDTH-1:0] DIFF,
    output logic             Borrow_out
);

    // borrow_chain[i] is the borrow into bit i; the top entry is the MSB borrow out.
    logic [WIDTH:0]   borrow_chain;
    logic [WIDTH-1:0] diff_comb;
    logic [WIDTH:0]   result_q;

    assign borrow_chain[0] = Borrow_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_subtractor u_fs (
            .a    (A[i]),
            .b    (B[i]),
            .bin  (borrow_chain[i]),
            .d    (diff_comb[i]),
            .bout (borrow_chain[i+1])
        );
    end

    // Output register; async clear so outputs drop to zero as soon as reset asserts.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            result_q <= '0;
        end else begin
            result_q <= {borrow_chain[WIDTH], diff_comb};
        end
    end

    assign DIFF       = result_q[WIDTH-1:0];
    assign Borrow_out = result_q[WIDTH];

endmodule : subtractor_8_bit

// File: tb/tb_subtractor_8_bit.sv
// Self-checking bench for subtractor_8_bit against an integer-arithmetic model.
module tb_subtractor_8_bit;

    logic       Clock;
    logic       Reset_n;
    logic [7:0] A;
    logic [7:0] B;
    logic       Borrow_in;
    logic [7:0] DIFF;
    logic       Borrow_out;

    int total = 0;
    int bad   = 0;

    subtractor_8_bit dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .A          (A),
        .B          (B),
        .Borrow_in  (Borrow_in),
        .DIFF       (DIFF),
        .Borrow_out (Borrow_out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: plain signed integer subtraction, then wrap into 8 bits.
    function automatic logic [8:0] ref_result(input int a, input int b, input int bin);
        int full;
        int wrapped;
        logic bout;
        full    = a - b - bin;
        bout    = (full < 0);
        wrapped = (full + 512) % 256;
        return {bout, 8'(wrapped)};
    endfunction

    task automatic drive(input int a, input int b, input int bin);
        A         = 8'(a);
        B         = 8'(b);
        Borrow_in = 1'(bin);
    endtask

    // Drive operands, take one rising edge, sample 1 time unit later.
    task automatic run_vec(input string name, input int a, input int b, input int bin);
        logic [8:0] exp;
        drive(a, b, bin);
        exp = ref_result(a, b, bin);
        @(posedge Clock);
        #1;
        total++;
        if ({Borrow_out, DIFF} !== exp) begin
            bad++;
            $display("FAIL %s a=%0d b=%0d bin=%0d got diff=%0d bout=%0b want diff=%0d bout=%0b",
                     name, a, b, bin, DIFF, Borrow_out, exp[7:0], exp[8]);
        end
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        Reset_n = 1'b0;
        drive(10, 5, 0);
        #2;
        total++;
        if ({Borrow_out, DIFF} !== 9'd0) begin
            bad++;
            $display("FAIL reset_hold got diff=%0d bout=%0b want 0/0", DIFF, Borrow_out);
        end
        @(posedge Clock);
        #1;
        total++;
        if ({Borrow_out, DIFF} !== 9'd0) begin
            bad++;
            $display("FAIL reset_edge got diff=%0d bout=%0b want 0/0", DIFF, Borrow_out);
        end
        #2;
        Reset_n = 1'b1;
        exp = 9'd5;
        @(posedge Clock);
        #1;
        total++;
        if ({Borrow_out, DIFF} !== exp) begin
            bad++;
            $display("FAIL reset_release got diff=%0d bout=%0b want 5/0", DIFF, Borrow_out);
        end
    endtask

    task automatic test_directed();
        run_vec("dir_10_5", 10, 5, 0);
        total++;
        if (DIFF !== 8'd5 || Borrow_out !== 1'b0) begin
            bad++;
            $display("FAIL dir_10_5_const got %0d/%0b want 5/0", DIFF, Borrow_out);
        end
        run_vec("dir_5_10", 5, 10, 0);
        total++;
        if (DIFF !== 8'd251 || Borrow_out !== 1'b1) begin
            bad++;
            $display("FAIL dir_5_10_const got %0d/%0b want 251/1", DIFF, Borrow_out);
        end
        run_vec("dir_15_7_b", 15, 7, 1);
        total++;
        if (DIFF !== 8'd7 || Borrow_out !== 1'b0) begin
            bad++;
            $display("FAIL dir_15_7_const got %0d/%0b want 7/0", DIFF, Borrow_out);
        end
        run_vec("dir_0_1_b", 0, 1, 1);
        total++;
        if (DIFF !== 8'd254 || Borrow_out !== 1'b1) begin
            bad++;
            $display("FAIL dir_0_1_const got %0d/%0b want 254/1", DIFF, Borrow_out);
        end
    endtask

    task automatic test_boundaries();
        run_vec("bnd_0_255_b", 0, 255, 1);
        total++;
        if (DIFF !== 8'd0 || Borrow_out !== 1'b1) begin
            bad++;
            $display("FAIL bnd_full_wrap got %0d/%0b want 0/1", DIFF, Borrow_out);
        end
        run_vec("bnd_255_0", 255, 0, 0);
        total++;
        if (DIFF !== 8'd255 || Borrow_out !== 1'b0) begin
            bad++;
            $display("FAIL bnd_max got %0d/%0b want 255/0", DIFF, Borrow_out);
        end
        run_vec("bnd_128_128_b", 128, 128, 1);
        total++;
        if (DIFF !== 8'd255 || Borrow_out !== 1'b1) begin
            bad++;
            $display("FAIL bnd_equal_borrow got %0d/%0b want 255/1", DIFF, Borrow_out);
        end
        run_vec("bnd_0_0", 0, 0, 0);
        run_vec("bnd_255_255", 255, 255, 0);
        run_vec("bnd_255_255_b", 255, 255, 1);
    endtask

    // Inputs changing between edges must not reach the outputs.
    task automatic test_no_comb_path();
        logic [8:0] held;
        run_vec("hold_base", 200, 50, 0);
        held = ref_result(200, 50, 0);
        #1;
        drive(3, 90, 1);
        #2;
        total++;
        if ({Borrow_out, DIFF} !== held) begin
            bad++;
            $display("FAIL no_comb_path got diff=%0d bout=%0b want diff=%0d bout=%0b",
                     DIFF, Borrow_out, held[7:0], held[8]);
        end
        @(posedge Clock);
        #1;
        total++;
        if ({Borrow_out, DIFF} !== ref_result(3, 90, 1)) begin
            bad++;
            $display("FAIL no_comb_next got diff=%0d bout=%0b", DIFF, Borrow_out);
        end
    endtask

    task automatic test_back_to_back();
        int a, b, bin;
        for (int i = 0; i < 20; i++) begin
            a   = (i * 37 + 11) % 256;
            b   = (i * 91 + 200) % 256;
            bin = i % 2;
            run_vec("b2b", a, b, bin);
        end
        // Reset mid-stream: outputs clear before any edge.
        drive(77, 33, 0);
        #2;
        Reset_n = 1'b0;
        #1;
        total++;
        if ({Borrow_out, DIFF} !== 9'd0) begin
            bad++;
            $display("FAIL b2b_async_reset got diff=%0d bout=%0b want 0/0", DIFF, Borrow_out);
        end
        @(posedge Clock);
        #1;
        total++;
        if ({Borrow_out, DIFF} !== 9'd0) begin
            bad++;
            $display("FAIL b2b_reset_hold got diff=%0d bout=%0b want 0/0", DIFF, Borrow_out);
        end
        #2;
        Reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_vec("b2b_after_rst", (i * 53) % 256, (i * 29 + 7) % 256, (i + 1) % 2);
        end
    endtask

    task automatic test_random();
        int a, b, bin;
        for (int i = 0; i < 10000; i++) begin
            a   = int'($urandom_range(255));
            b   = int'($urandom_range(255));
            bin = int'($urandom_range(1));
            run_vec("random", a, b, bin);
        end
    endtask

    initial begin
        Reset_n   = 1'b0;
        A         = 8'd0;
        B         = 8'd0;
        Borrow_in = 1'b0;
        test_reset();
        test_directed();
        test_boundaries();
        test_no_comb_path();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_subtractor_8_bit

// File: doc/subtractor_8_bit.md
# subtractor_8_bit

Registered 8-bit ripple-borrow subtractor. Computes A − B − Borrow_in each cycle and presents the 8-bit two's-complement difference and the final borrow on registered outputs one clock after the operands are sampled. It is a datapath leaf block: upstream logic drives operands and borrow-in, and downstream logic consumes DIFF/Borrow_out. Borrow_in/Borrow_out allow several instances to be cascaded for wider words.

## Interface
- WIDTH, 8, operand and difference width in bits. Only 8 is verified.
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  minuend, unsigned.
- B  input  WIDTH  subtrahend, unsigned.
- Borrow_in  input  1  borrow into bit 0; subtracts an extra 1.
- DIFF  output  WIDTH  registered (A − B − Borrow_in) mod 2^WIDTH.
- Borrow_out  output  1  registered borrow out of the MSB.

## Operation
- Combinational core: ripple chain of WIDTH one-bit full subtractors, with bit 0 borrow = Borrow_in.
- Per bit i:
  - d_i = a_i ^ b_i ^ bin_i
  - bout_i = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i)
- Borrow_out = bout of the MSB.
- Borrow_out is 1 exactly when A < B + Borrow_in, treating A and B as unsigned.
- Width rule: {Borrow_out, DIFF} equals the (WIDTH+1)-bit result of A − B − Borrow_in, two's complement.
- Negative results wrap modulo 2^WIDTH. Example: 5 − 10 gives DIFF = 251 with Borrow_out = 1.
- Operands are interpreted as unsigned. No signed-overflow flag.
- No enable and no handshake. A new result is registered every cycle.

## Timing
- Latency: 1 clock. Operands stable at rising edge N produce DIFF/Borrow_out valid after edge N, held until edge N+1.
- Throughput: one result per cycle, fully pipelined.
- Reset asserted (Reset_n = 0): DIFF = 0 and Borrow_out = 0 immediately, without waiting for a clock edge.
- Outputs hold 0 while reset is asserted.
- First result after release: operands present at the first rising edge after Reset_n rises.
- Reset during operation discards the in-flight result. No partial state remains.
- Inputs changing between edges have no effect on outputs until the next rising edge. There is no combinational input-to-output path.
- Extreme cases:
  - A = 0, B = 255, Borrow_in = 1: DIFF = 0, Borrow_out = 1 (full wrap).
  - A = B with Borrow_in = 1: DIFF = 255, Borrow_out = 1.

## Structure
- Shared package sub_pkg holds the constant DATA_W = 8, used as the WIDTH default.
- Sub-module full_subtractor (ports a, b, bin, d, bout), purely combinational.
  - The top instantiates WIDTH copies in a generate loop, chaining bout to the next bin.
- Top contains the chain plus one output register of WIDTH+1 bits with async active-low clear.

## Test plan
- Reset: hold Reset_n = 0 with nonzero inputs (A = 10, B = 5) -> DIFF = 0 and Borrow_out = 0 without a clock edge. Release reset -> result 5/0 after the next rising edge.
- A = 10, B = 5, Borrow_in = 0 -> one cycle later DIFF = 5, Borrow_out = 0. A = 5, B = 10, Borrow_in = 0 -> DIFF = 251, Borrow_out = 1.
- A = 15, B = 7, Borrow_in = 1 -> DIFF = 7, Borrow_out = 0. A = 0, B = 1, Borrow_in = 1 -> DIFF = 254, Borrow_out = 1.
- Boundaries:
  - A = 0, B = 255, Borrow_in = 1 -> DIFF = 0, Borrow_out = 1.
  - A = 255, B = 0, Borrow_in = 0 -> 255/0.
  - A = B = 128, Borrow_in = 1 -> 255/1.
- Back-to-back: a new operand set every cycle -> each result appears exactly one edge later with no bubbles. Asserting reset in the middle of the stream clears outputs asynchronously.
- Random: 10k random A/B/Borrow_in values -> {Borrow_out, DIFF} matches the 9-bit reference A − B − Borrow_in, delayed one cycle.
